// File: rtl/ofmap_piso_pkg.sv
// Shared types and helpers for the ofmap parallel-in/serial-out unchainer.
package ofmap_piso_pkg;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_SHIFT = 1'b1
  } sh_state_e;

  // A lane count of zero or above the lane total means "all lanes".
  function automatic int clamp_lanes(input int n, input int oc0);
    return (n == 0 || n > oc0) ? oc0 : n;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// Holding register for one chained word plus its lane count, with a valid flag.
module piso_hold_reg #(
  parameter int W  = 128,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          unload,
  input  logic [W-1:0]  d_dat,
  input  logic [CW-1:0] d_cnt,
  output logic [W-1:0]  q_dat,
  output logic [CW-1:0] q_cnt,
  output logic          full
);

  // A load in the same cycle as an unload wins, so the new word stays held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full  <= 1'b0;
      q_dat <= '0;
      q_cnt <= '0;
    end else if (load) begin
      full  <= 1'b1;
      q_dat <= d_dat;
      q_cnt <= d_cnt;
    end else if (unload) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/ofmap_piso_db.sv
// Double-buffered unchainer: takes OC0-lane chained words and emits one lane per beat.
//   state   | meaning
//   S_EMPTY | shifter holds no word, out_vld low
//   S_SHIFT | shifter presents lane[idx] of the current word
module ofmap_piso_db
  import ofmap_piso_pkg::*;
#(
  parameter int DATA_WID = 32,
  parameter int OC0      = 4,
  parameter int CNT_WID  = $clog2(OC0 + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_WID*OC0-1:0] in_dat,
  input  logic [CNT_WID-1:0]      in_num_lanes,
  output logic [DATA_WID-1:0]     out_dat,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    out_last,
  output logic                    busy
);

  sh_state_e                 state, state_nxt;
  logic [DATA_WID*OC0-1:0]   hold_dat, sh_dat;
  logic [CNT_WID-1:0]        hold_cnt, in_cnt, sh_n, idx, idx_nxt;
  logic [DATA_WID-1:0]       lane_sel;
  logic                      hold_full, hold_xfer, in_fire, out_fire, sh_full, sh_load;

  assign in_cnt    = CNT_WID'(clamp_lanes(int'(in_num_lanes), OC0));
  assign sh_full   = (state == S_SHIFT);
  assign out_vld   = sh_full;
  assign out_last  = sh_full && (idx == sh_n - CNT_WID'(1));
  assign out_fire  = out_vld && out_rdy;
  // in_rdy depends combinationally on out_rdy through hold_xfer; this path is intended.
  assign hold_xfer = hold_full && (!sh_full || (out_fire && out_last));
  assign in_rdy    = rst_n && (!hold_full || hold_xfer);
  assign in_fire   = in_vld && in_rdy;
  assign busy      = hold_full || sh_full;

  piso_hold_reg #(
    .W  (DATA_WID*OC0),
    .CW (CNT_WID)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (in_fire),
    .unload (hold_xfer),
    .d_dat  (in_dat),
    .d_cnt  (in_cnt),
    .q_dat  (hold_dat),
    .q_cnt  (hold_cnt),
    .full   (hold_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_EMPTY;
      idx    <= '0;
      sh_dat <= '0;
      sh_n   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (sh_load) begin
        sh_dat <= hold_dat;
        sh_n   <= hold_cnt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sh_load   = 1'b0;
    case (state)
      S_EMPTY: begin
        if (hold_xfer) begin
          sh_load   = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (out_fire) begin
          if (!out_last) begin
            idx_nxt = idx + CNT_WID'(1);
          end else if (hold_xfer) begin
            sh_load = 1'b1;
            idx_nxt = '0;
          end else begin
            state_nxt = S_EMPTY;
          end
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    lane_sel = '0;
    for (int k = 0; k < OC0; k++) begin
      if (idx == CNT_WID'(k)) lane_sel = sh_dat[k*DATA_WID +: DATA_WID];
    end
  end

  assign out_dat = sh_full ? lane_sel : '0;

endmodule

// File: tb/tb_ofmap_piso_db.sv
// Scoreboard bench for ofmap_piso_db: accepted words expand into expected beats.
module tb_ofmap_piso_db;

  localparam int DW  = 32;
  localparam int OC0 = 4;
  localparam int CW  = 3;

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              in_vld;
  logic              in_rdy;
  logic [DW*OC0-1:0] in_dat;
  logic [CW-1:0]     in_num_lanes;
  logic [DW-1:0]     out_dat;
  logic              out_vld;
  logic              out_rdy;
  logic              out_last;
  logic              busy;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_cnt = 0;
  int    toggle_mode = 0;
  beat_t exp_q[$];
  int    beat_cyc_q[$];
  logic          stall_pending = 1'b0;
  logic [DW-1:0] stall_dat;
  logic          stall_last;

  ofmap_piso_db #(.DATA_WID(DW), .OC0(OC0), .CNT_WID(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_dat       (in_dat),
    .in_num_lanes (in_num_lanes),
    .out_dat      (out_dat),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_last     (out_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Reference: a word of n lanes (0 or >OC0 means OC0) becomes n beats, lane 0 first.
  function automatic void model_push(logic [DW*OC0-1:0] d, logic [CW-1:0] n);
    int    ne;
    beat_t b;
    ne = (n == 0 || int'(n) > OC0) ? OC0 : int'(n);
    for (int k = 0; k < ne; k++) begin
      b.dat  = d[k*DW +: DW];
      b.last = (k == ne - 1);
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        chk("stall_vld", 32'(out_vld), 32'd1);
        chk("stall_dat", out_dat, stall_dat);
        chk("stall_last", 32'(out_last), 32'(stall_last));
      end
      if (out_vld && out_rdy) begin
        beat_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          fail_now("extra_beat");
        end else begin
          e = exp_q.pop_front();
          chk("beat_dat", out_dat, e.dat);
          chk("beat_last", 32'(out_last), 32'(e.last));
        end
      end
      stall_pending = out_vld && !out_rdy;
      stall_dat     = out_dat;
      stall_last    = out_last;
      if (in_vld && in_rdy) begin
        acc_cnt++;
        model_push(in_dat, in_num_lanes);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (toggle_mode == 1) out_rdy = ~out_rdy;
    else if (toggle_mode == 2) out_rdy = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*OC0-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered at posedge+1; leaves in_vld high at posedge+1 after the transfer edge.
  task automatic send_word(input logic [DW*OC0-1:0] d, input logic [CW-1:0] n, output int waits);
    bit done;
    in_dat       = d;
    in_num_lanes = n;
    in_vld       = 1'b1;
    waits        = 0;
    done         = 0;
    while (!done) begin
      @(negedge clk);
      if (in_rdy) done = 1;
      else if (waits >= 200) begin
        fail_now("send_timeout");
        done = 1;
      end else waits++;
      tick();
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("drain_timeout");
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [DW-1:0] la, lb, lc, ld;
    rst_n = 1'b0; in_vld = 1'b0; in_dat = '0; in_num_lanes = '0; out_rdy = 1'b1;

    // Reset and idle
    repeat (5) tick();
    @(negedge clk);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_dat", out_dat, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("post_rst_out_vld", 32'(out_vld), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    tick();

    // Single word, latency and last flag
    la = 32'hAAAA_0001; lb = 32'hBBBB_0002; lc = 32'hCCCC_0003; ld = 32'hDDDD_0004;
    in_dat = {ld, lc, lb, la}; in_num_lanes = 3'd4; in_vld = 1'b1;
    @(negedge clk);
    chk("sw_in_rdy", 32'(in_rdy), 32'd1);
    tick();
    in_vld = 1'b0;
    @(negedge clk);
    chk("sw_t1_out_vld", 32'(out_vld), 32'd0);
    chk("sw_t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("sw_beat_vld", 32'(out_vld), 32'd1);
      chk("sw_beat_last", 32'(out_last), 32'(i == 3));
    end
    tick();
    @(negedge clk);
    chk("sw_t6_busy", 32'(busy), 32'd0);
    chk("sw_t6_out_vld", 32'(out_vld), 32'd0);
    tick();

    // Streaming single-lane words
    beat_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      send_word(rand_word(), 3'd1, w);
      chk("stream_in_rdy_wait", 32'(w), 32'd0);
    end
    in_vld = 1'b0;
    wait_drain();
    chk("stream_beats", 32'(beat_cyc_q.size()), 32'd8);
    if (beat_cyc_q.size() > 0)
      chk("stream_gapless", 32'(beat_cyc_q[$] - beat_cyc_q[0]), 32'd7);

    // Backpressure: two words buffer, third is refused until the output moves
    out_rdy = 1'b0;
    w = acc_cnt;
    send_word(rand_word(), 3'd4, w);
    chk("bp_w0_wait", 32'(w), 32'd0);
    w = acc_cnt;
    send_word(rand_word(), 3'd3, w);
    chk("bp_w1_wait", 32'(w), 32'd0);
    w = acc_cnt;
    in_dat = rand_word(); in_num_lanes = 3'd2; in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_rdy_low", 32'(in_rdy), 32'd0);
      chk("bp_out_vld", 32'(out_vld), 32'd1);
      tick();
    end
    chk("bp_no_accept", 32'(acc_cnt - w), 32'd0);
    toggle_mode = 1;
    send_word(in_dat, in_num_lanes, w);
    in_vld = 1'b0;
    wait_drain();
    toggle_mode = 0;
    out_rdy = 1'b1;
    tick();

    // Lane-count clamp
    beat_cyc_q.delete();
    send_word(rand_word(), 3'd0, w); in_vld = 1'b0; wait_drain();
    chk("clamp_n0_beats", 32'(beat_cyc_q.size()), 32'd4);
    beat_cyc_q.delete();
    send_word(rand_word(), 3'd7, w); in_vld = 1'b0; wait_drain();
    chk("clamp_n7_beats", 32'(beat_cyc_q.size()), 32'd4);
    beat_cyc_q.delete();
    send_word(rand_word(), 3'd2, w); in_vld = 1'b0; wait_drain();
    chk("clamp_n2_beats", 32'(beat_cyc_q.size()), 32'd2);

    // Mid-word reset
    beat_cyc_q.delete();
    send_word(rand_word(), 3'd4, w);
    in_vld = 1'b0;
    tick(); tick(); tick();
    chk("mid_rst_pre_beats", 32'(beat_cyc_q.size()), 32'd2);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("mid_rst_idle_vld", 32'(out_vld), 32'd0);
    tick();
    beat_cyc_q.delete();
    send_word(rand_word(), 3'd4, w); in_vld = 1'b0; wait_drain();
    chk("mid_rst_new_beats", 32'(beat_cyc_q.size()), 32'd4);

    // Random traffic with random backpressure
    toggle_mode = 2;
    for (int i = 0; i < 30; i++) begin
      send_word(rand_word(), 3'($urandom_range(0, 7)), w);
      if ($urandom_range(0, 2) == 0) begin
        in_vld = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
    end
    in_vld = 1'b0;
    toggle_mode = 0;
    out_rdy = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofmap_piso_db.md
Name: ofmap_piso_db

Overview:
- Parametrised, double-buffered parallel-in/serial-out unchainer for MAC-array ofmap output.
- Accepts one OC0-lane chained word per valid/ready handshake and emits lanes one per beat on a serial valid/ready bus to the testbench/output stream.
- A holding register accepts the next chained word while the current one is still shifting, giving sustained 1 beat/cycle throughput.
- Active lane count is selectable per word.

Parameters:
- DATA_WID, 32, width of one lane / serial beat
- OC0, 4, lanes per chained word
- CNT_WID, $clog2(OC0+1), width of lane count/index fields

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_vld  in  1  chained word valid
- in_rdy  out  1  block can accept chained word this cycle
- in_dat  in  DATA_WID*OC0  chained word; lane k at bits [(k+1)*DATA_WID-1 : k*DATA_WID]
- in_num_lanes  in  CNT_WID  active lanes for this word (1..OC0), sampled with in_dat
- out_dat  out  DATA_WID  serial lane data
- out_vld  out  1  out_dat valid
- out_rdy  in  1  downstream accepts beat
- out_last  out  1  current beat is final active lane of its word
- busy  out  1  holding register or shifter occupied

Behaviour:
- Reset is synchronous, active-low; clock clk. While rst_n is low, and at the first cycle after release: out_vld=0, out_last=0, out_dat=0, busy=0, hold and shifter empty, lane index=0. in_rdy=0 while rst_n is low and 1 in the first cycle after release.
- Reset mid-operation discards all buffered data; no partial word is emitted afterwards.
- Input handshake: a transfer occurs when in_vld && in_rdy. The word and its clamped lane count are captured into the holding register.
- Lane-count clamp: in_num_lanes of 0 or greater than OC0 is treated as OC0.
- Holding register: flag hold_full.
  - hold_xfer = hold_full && (!sh_full || (out_vld && out_rdy && out_last)).
  - in_rdy = !hold_full || hold_xfer. This is combinational from out_rdy; the path is documented and accepted.
- Shifter FSM, states S_EMPTY and S_SHIFT:
  - S_EMPTY: out_vld=0. On hold_xfer, load lanes, set idx=0 and n=hold count, go to S_SHIFT.
  - S_SHIFT: out_vld=1, out_dat=lane[idx], out_last=(idx==n-1).
    - On out_vld && out_rdy && !out_last: idx++.
    - On a handshake with out_last: if hold_xfer, reload and stay in S_SHIFT with idx=0; else go to S_EMPTY.
- AXI rule: once out_vld=1, out_dat and out_last stay stable until out_rdy is sampled high. out_vld never drops without a handshake, except on reset.
- Latency: handshake on input in cycle t -> hold_full in t+1 -> first beat out_vld=1 in cycle t+2 (shifter empty, no stall).
- Throughput: with out_rdy held high, back-to-back words give continuous out_vld with no bubble for any lane count, including n=1. in_rdy stays high.
- Backpressure: with out_rdy=0, at most 2 words are buffered (shifter + hold), then in_rdy=0. No data loss or duplication.
- Simultaneous load into hold and transfer out of hold in the same cycle is legal; the new word lands in hold.
- Ordering: lane 0 first, ascending; words strictly in acceptance order.
- busy = hold_full || (state == S_SHIFT).

Decomposition:
- Package ofmap_piso_pkg holds:
  - state enum (S_EMPTY, S_SHIFT)
  - lane-count clamp function
- Sub-module piso_hold_reg: DATA_WID*OC0 + CNT_WID register with valid flag, load/unload enables, and synchronous reset.
- FSM, lane mux and index counter live in the top module.

Test Plan:
- Reset/idle: hold rst_n=0 5 cycles, release -> out_vld=0, busy=0, in_rdy=1 in first post-reset cycle.
- Single word: OC0=4, in_dat={D,C,B,A}, n=4, out_rdy=1 -> out_dat A,B,C,D in cycles t+2..t+5; out_last only on D; busy clears at t+6.
- Streaming, n=1: words W0..W7 on consecutive cycles, out_rdy=1 -> 8 consecutive out_vld beats, in_rdy never low, each out_last=1.
- Backpressure: out_rdy=0, offer 3 words -> 2 accepted, in_rdy=0. Toggle out_rdy 1010... -> beats complete, in order, out_dat stable while stalled.
- Clamp: n=0 and n=7 (OC0=4) -> both emit 4 beats; n=2 emits lanes 0,1 only, last on lane 1.
- Mid-word reset: assert rst_n=0 after 2 of 4 beats -> out_vld=0 next cycle; after release, a new word emits from lane 0 with no stale beats.
